// File: rtl/thread_mt_pkg.sv
// Shared types, ISA constants and decode helpers for the barrel-multithreaded
// sequencer. Optional feature macro: THREAD_MT_BRANCH_EN (JAL/BRANCH support).
package thread_mt_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_MEM  = 2'd1,
        UNIT_SEL_ALU  = 2'd2
    } unit_sel_t;

    localparam word_t MEM_CTRL_READ  = 32'h0000_0001;
    localparam word_t MEM_CTRL_WRITE = 32'h0000_0002;

    localparam word_t ALU_CTRL_ADD  = 32'd0;
    localparam word_t ALU_CTRL_SUB  = 32'd1;
    localparam word_t ALU_CTRL_SLL  = 32'd2;
    localparam word_t ALU_CTRL_SLT  = 32'd3;
    localparam word_t ALU_CTRL_SLTU = 32'd4;
    localparam word_t ALU_CTRL_XOR  = 32'd5;
    localparam word_t ALU_CTRL_SRL  = 32'd6;
    localparam word_t ALU_CTRL_SRA  = 32'd7;
    localparam word_t ALU_CTRL_OR   = 32'd8;
    localparam word_t ALU_CTRL_AND  = 32'd9;
    localparam word_t ALU_CTRL_EQ   = 32'd10;
    localparam word_t ALU_CTRL_NE   = 32'd11;
    localparam word_t ALU_CTRL_LT   = 32'd12;
    localparam word_t ALU_CTRL_GE   = 32'd13;
    localparam word_t ALU_CTRL_LTU  = 32'd14;
    localparam word_t ALU_CTRL_GEU  = 32'd15;

    localparam logic [6:0] ISA_OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] ISA_OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] ISA_OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] ISA_OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] ISA_OPCODE_BRANCH = 7'b1100011;

`ifdef THREAD_MT_BRANCH_EN
    typedef enum logic [2:0] {FETCH, EXEC, EXEC_IMM, LINK, BRANCH_CMP, PC_UPD} thread_state_t;
`else
    typedef enum logic [2:0] {FETCH, EXEC, EXEC_IMM, PC_UPD} thread_state_t;
`endif

    // Immediate extraction for every format the sequencer consumes.
    function automatic word_t immed_gen(input word_t inst);
        case (inst[6:0])
            ISA_OPCODE_OP_IMM: immed_gen = {{20{inst[31]}}, inst[31:20]};
            ISA_OPCODE_LUI:    immed_gen = {inst[31:12], 12'b0};
            ISA_OPCODE_JAL:    immed_gen = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            ISA_OPCODE_BRANCH: immed_gen = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            default:           immed_gen = '0;
        endcase
    endfunction

    // ALU operation for OP / OP_IMM; everything else (LUI included) adds.
    function automatic word_t alu_ctrl_gen(input logic [6:0] opcode, input logic [2:0] funct3,
                                           input logic alt);
        alu_ctrl_gen = ALU_CTRL_ADD;
        if (opcode == ISA_OPCODE_OP || opcode == ISA_OPCODE_OP_IMM) begin
            case (funct3)
                3'b000:  alu_ctrl_gen = (alt && opcode == ISA_OPCODE_OP) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
                3'b001:  alu_ctrl_gen = ALU_CTRL_SLL;
                3'b010:  alu_ctrl_gen = ALU_CTRL_SLT;
                3'b011:  alu_ctrl_gen = ALU_CTRL_SLTU;
                3'b100:  alu_ctrl_gen = ALU_CTRL_XOR;
                3'b101:  alu_ctrl_gen = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
                3'b110:  alu_ctrl_gen = ALU_CTRL_OR;
                default: alu_ctrl_gen = ALU_CTRL_AND;
            endcase
        end
    endfunction

    // Branch compare selection from funct3; reserved encodings compare EQ.
    function automatic word_t branch_ctrl_gen(input logic [2:0] funct3);
        case (funct3)
            3'b001:  branch_ctrl_gen = ALU_CTRL_NE;
            3'b100:  branch_ctrl_gen = ALU_CTRL_LT;
            3'b101:  branch_ctrl_gen = ALU_CTRL_GE;
            3'b110:  branch_ctrl_gen = ALU_CTRL_LTU;
            3'b111:  branch_ctrl_gen = ALU_CTRL_GEU;
            default: branch_ctrl_gen = ALU_CTRL_EQ;
        endcase
    endfunction

    // Step that follows FETCH for the freshly fetched opcode.
    function automatic thread_state_t step_after_fetch(input logic [6:0] opcode);
        case (opcode)
            ISA_OPCODE_OP:     step_after_fetch = EXEC;
            ISA_OPCODE_OP_IMM: step_after_fetch = EXEC_IMM;
            ISA_OPCODE_LUI:    step_after_fetch = EXEC_IMM;
`ifdef THREAD_MT_BRANCH_EN
            ISA_OPCODE_JAL:    step_after_fetch = LINK;
            ISA_OPCODE_BRANCH: step_after_fetch = BRANCH_CMP;
`endif
            default:           step_after_fetch = PC_UPD;
        endcase
    endfunction

endpackage

// File: rtl/thread_mt_reg_file_banked.sv
// Banked register file: one 32-word bank per hardware thread, addressed {tid, reg}.
// x0 reads as zero and writes to it are dropped. Contents clear on reset.
module reg_file_banked
    import thread_mt_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 2,
    localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TID_W-1:0] tid,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output word_t            rs1_data,
    output word_t            rs2_data,
    input  logic             we,
    input  logic [4:0]       rd_addr,
    input  word_t            rd_data
);

    word_t regs [32*NUM_THREADS];

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[{tid, rs1_addr}];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[{tid, rs2_addr}];

    // Write port; reset clears every bank so a dropped write leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32*NUM_THREADS; i++) regs[i] <= '0;
        end else if (we && rd_addr != 5'd0) begin
            regs[{tid, rd_addr}] <= rd_data;
        end
    end

endmodule

// File: rtl/thread_mt.sv
// Barrel-multithreaded RV32 sequencer: NUM_THREADS contexts interleaved
// round-robin onto one shared unit bus, each step waiting for unit_ready.
// Optional feature macro: THREAD_MT_BRANCH_EN enables JAL and BRANCH.
module thread_mt
    import thread_mt_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 2,
    parameter word_t       RESET_PC    = 32'h0,
    parameter word_t       PC_STRIDE   = 32'h400,
    localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output unit_sel_t        unit_sel,
    output word_t            unit_ctrl,
    output word_t [1:0]      unit_in,
    input  word_t            unit_out,
    input  logic             unit_ready,
    output logic [TID_W-1:0] unit_tid
);

    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

    thread_state_t    state_q [NUM_THREADS];
    word_t            pc_q    [NUM_THREADS];
    word_t            inst_q  [NUM_THREADS];
`ifdef THREAD_MT_BRANCH_EN
    logic             taken_q [NUM_THREADS];
`endif
    logic [TID_W-1:0] tid_q;

    thread_state_t cur_state;
    word_t         cur_pc, cur_inst, immed, alu_ctrl, rs1_val, rs2_val;
    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic          rf_we;

    assign cur_state = state_q[tid_q];
    assign cur_pc    = pc_q[tid_q];
    assign cur_inst  = inst_q[tid_q];
    assign opcode    = cur_inst[6:0];
    assign rd        = cur_inst[11:7];
    assign funct3    = cur_inst[14:12];
    assign rs1       = cur_inst[19:15];
    assign rs2       = cur_inst[24:20];
    assign immed     = immed_gen(cur_inst);
    assign alu_ctrl  = alu_ctrl_gen(opcode, funct3, cur_inst[30]);
    assign unit_tid  = tid_q;

    reg_file_banked #(.NUM_THREADS(NUM_THREADS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .tid      (tid_q),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (rf_we),
        .rd_addr  (rd),
        .rd_data  (unit_out)
    );

    // Bus request for the current thread's step, plus the rd write strobe.
    always_comb begin
        unit_sel  = UNIT_SEL_ALU;
        unit_ctrl = ALU_CTRL_ADD;
        unit_in   = '0;
        rf_we     = 1'b0;
        case (cur_state)
            FETCH: begin
                unit_sel   = UNIT_SEL_MEM;
                unit_ctrl  = MEM_CTRL_READ;
                unit_in[0] = cur_pc;
            end
            EXEC: begin
                unit_ctrl  = alu_ctrl;
                unit_in[0] = rs1_val;
                unit_in[1] = rs2_val;
                rf_we      = unit_ready;
            end
            EXEC_IMM: begin
                // LUI's rs1 field holds immediate bits, so force the x0 operand.
                unit_ctrl  = alu_ctrl;
                unit_in[0] = (opcode == ISA_OPCODE_LUI) ? '0 : rs1_val;
                unit_in[1] = immed;
                rf_we      = unit_ready;
            end
`ifdef THREAD_MT_BRANCH_EN
            LINK: begin
                unit_in[0] = cur_pc;
                unit_in[1] = 32'd4;
                rf_we      = unit_ready;
            end
            BRANCH_CMP: begin
                unit_ctrl  = branch_ctrl_gen(funct3);
                unit_in[0] = rs1_val;
                unit_in[1] = rs2_val;
            end
`endif
            PC_UPD: begin
                unit_in[0] = cur_pc;
`ifdef THREAD_MT_BRANCH_EN
                // taken is qualified by opcode: it is only refreshed by branches.
                unit_in[1] = ((opcode == ISA_OPCODE_JAL) ||
                              (opcode == ISA_OPCODE_BRANCH && taken_q[tid_q])) ? immed : 32'd4;
`else
                unit_in[1] = 32'd4;
`endif
            end
            default: ;
        endcase
    end

    // Per-thread context update and round-robin advance on each completed step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid_q <= '0;
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= FETCH;
                pc_q[t]    <= RESET_PC + word_t'(t) * PC_STRIDE;
                inst_q[t]  <= '0;
`ifdef THREAD_MT_BRANCH_EN
                taken_q[t] <= 1'b0;
`endif
            end
        end else if (unit_ready) begin
            case (cur_state)
                FETCH: begin
                    inst_q[tid_q]  <= unit_out;
                    state_q[tid_q] <= step_after_fetch(unit_out[6:0]);
                end
`ifdef THREAD_MT_BRANCH_EN
                BRANCH_CMP: begin
                    taken_q[tid_q] <= unit_out[0];
                    state_q[tid_q] <= PC_UPD;
                end
`endif
                PC_UPD: begin
                    pc_q[tid_q]    <= unit_out;
                    state_q[tid_q] <= FETCH;
                end
                default: state_q[tid_q] <= PC_UPD;
            endcase
            tid_q <= (tid_q == LAST_TID) ? '0 : tid_q + 1'b1;
        end
    end

endmodule

// File: doc/thread_mt.md
# thread_mt

Barrel-multithreaded successor to the single-thread sequencer. It holds NUM_THREADS independent RV32 contexts (pc, step counter, latched instruction, banked registers) and interleaves them round-robin onto the one shared unit bus. Each bus step completes only when the unit signals ready, so memory and ALU latency are tolerated. It sits between the core top and the shared unit mux (memory, ALU).

## Interface
- NUM_THREADS, 2: hardware contexts, 1..8; TID_W = max(1, $clog2(NUM_THREADS)).
- RESET_PC, 0: reset pc of thread 0.
- PC_STRIDE, 'h400: reset pc of thread t = RESET_PC + t*PC_STRIDE.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- unit_sel  out  unit_sel_t  target unit of the current step.
- unit_ctrl  out  word_t  unit control word.
- unit_in[1:0]  out  2 x word_t  operands.
- unit_out  in  word_t  unit result.
- unit_ready  in  1  unit_out valid; the current step completes this edge.
- unit_tid  out  TID_W  thread owning the current step.

## Operation
- Per-thread step states: FETCH, EXEC, EXEC_IMM, LINK, BRANCH_CMP, PC_UPD.
- Opcode sequences:
  - OP: FETCH -> EXEC -> PC_UPD.
  - OP_IMM: FETCH -> EXEC_IMM -> PC_UPD.
  - LUI: FETCH -> EXEC_IMM (ALU ADD, x0 + immed) -> PC_UPD.
  - JAL: FETCH -> LINK -> PC_UPD.
  - BRANCH: FETCH -> BRANCH_CMP -> PC_UPD.
  - Any other opcode: FETCH -> PC_UPD (NOP).
- FETCH: MEM, MEM_CTRL_READ, in0 = pc, in1 = 0; inst[tid] <= unit_out.
- EXEC: ALU, alu_ctrl, rs1, rs2; rd <= unit_out.
- EXEC_IMM: ALU, alu_ctrl, rs1, immed; rd <= unit_out.
- LINK: ALU ADD, pc, 4; rd <= unit_out.
- BRANCH_CMP: ALU with compare ctrl from funct3 (EQ, NE, LT, GE, LTU, GEU); taken[tid] <= unit_out[0].
- PC_UPD: ALU ADD, in0 = pc, in1 = immed if (JAL or taken), else 4; pc[tid] <= unit_out.
- Register file is banked: address {tid, reg}, 32 x NUM_THREADS words. Writes to x0 are discarded; x0 reads return 0.
- Round-robin: after a completed step (unit_ready = 1), tid <= (tid + 1) mod NUM_THREADS.
- pc arithmetic is 32-bit and wraps modulo 2^32.
- With NUM_THREADS = 1, behaviour equals the single-thread sequencer plus the ready handshake.

## Timing
- Outputs are combinational from (tid, state[tid], context).
- Reset values: tid = 0, all states FETCH, pc[t] per PC_STRIDE, inst = 0, taken = 0. Hence after reset: unit_sel = UNIT_SEL_MEM, unit_ctrl = MEM_CTRL_READ, unit_in[0] = RESET_PC, unit_in[1] = 0, unit_tid = 0.
- unit_ready = 0: no state, pc, inst, register or tid change; outputs held stable until ready.
- One step completes per ready cycle. Minimum instruction period per thread = steps x NUM_THREADS cycles.
- Register write and state advance happen on the same edge as unit_ready = 1. The next step of the same thread reads the new value (no bypass needed; earliest reuse is NUM_THREADS cycles later).
- rst asserted mid-step: all contexts return to reset values immediately. A pending write is dropped.

## Configuration
- THREAD_MT_BRANCH_EN
  - Defined: JAL and BRANCH sequences as above; taken flag per thread.
  - Undefined: JAL and BRANCH decode as NOP (FETCH -> PC_UPD with +4); LINK and BRANCH_CMP states and taken storage are removed.

## Structure
- Shared package types.sv:
  - thread_state_t extended with LINK, BRANCH_CMP, PC_UPD.
  - ISA_OPCODE_LUI, ISA_OPCODE_JAL, ISA_OPCODE_BRANCH.
  - ALU compare ctrl constants.
  - Existing UNIT_SEL_* and MEM_CTRL_*.
- Reuse alu_ctrl_gen and immed_gen on the selected inst[tid].
- New sub-module reg_file_banked (parameter NUM_THREADS) replaces reg_file.
- Per-thread context arrays live in thread_mt.

## Test plan
- Reset: NUM_THREADS = 2, PC_STRIDE = 'h400, ready held 1 -> cycle 0 fetch pc 0 tid 0; cycle 1 fetch pc 'h400 tid 1.
- ADDI x1,x0,5 then ADD x2,x1,x1 in thread 0; thread 1 runs NOPs -> x2[t0] = 10, x2[t1] = 0, pc[t0] = 8.
- Ready stall: ready low 3 cycles during an EXEC step -> outputs constant, no register write, tid unchanged; completes on the first ready high.
- BEQ x0,x0,+16 at pc 'h20 (macro on) -> pc = 'h30. BNE x0,x0,+16 -> pc = 'h24. JAL x1,-8 at 'h40 -> x1 = 'h44, pc = 'h38.
- Macro off: same JAL -> x1 unchanged, pc = 'h44.
- Async reset asserted mid-EXEC, between edges -> outputs show the thread 0 fetch at RESET_PC immediately; no register write occurs.
